theta_iter_seq: RTL and testbench



---
 rtl/timing_core_pkg.sv | 18 +
 rtl/theta_pace_cnt.sv | 30 +++
 rtl/theta_iter_seq.sv | 167 ++++++++++++++++
 tb/tb_theta_iter_seq.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/timing_core_pkg.sv
// Shared definitions for the theta iteration sequencer: iteration width,
// sequencer state encoding and the sweep-length helper.
package timing_core_pkg;

    localparam int ITER_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } seq_state_t;

    // Number of distinct iteration indices in one unidirectional sweep.
    function automatic int total_iters(input int points, input int frames);
        return points * frames;
    endfunction

endpackage

// File: rtl/theta_pace_cnt.sv
// Pacing down-counter. A load presets PACE_DIV_P-1; expire is high on the
// last wait cycle so the sequencer can move back to ISSUE on the next edge.
// With PACE_DIV_P == 1 the counter is never waited on and expire stays low.
module theta_pace_cnt #(
    parameter int PACE_DIV_P = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expire
);

    localparam int CW = $clog2(PACE_DIV_P + 1);

    logic [CW-1:0] cnt;

    // Preset on load, otherwise count down and stop at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(PACE_DIV_P - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign expire = (cnt == CW'(1));

endmodule

// File: rtl/theta_iter_seq.sv
// Theta iteration sequencer: issues scan iteration indices 0..POINTS*FRAMES-1
// at a paced rate, with point/frame indices and line/sweep completion strobes.
// Optional THETA_ITER_BIDIR_EN: after the peak the sweep counts back down to 0.
//
//   state | meaning
//   IDLE  | no sweep in progress, waiting for start
//   ISSUE | valid strobe cycle for the current iteration
//   WAIT  | pacing gap between two issued iterations
module theta_iter_seq
    import timing_core_pkg::*;
#(
    parameter int POINTS_PER_LINE_P  = 360,
    parameter int NUMBER_OF_FRAMES_P = 5,
    parameter int PACE_DIV_P         = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              stop_i,
    output logic              theta_iteration_valid_o,
    output logic [ITER_W-1:0] theta_iteration_o,
    output logic [ITER_W-1:0] point_idx_o,
    output logic [ITER_W-1:0] frame_idx_o,
    output logic              line_done_o,
    output logic              sweep_done_o,
    output logic              busy_o
);

    localparam int TOTAL = total_iters(POINTS_PER_LINE_P, NUMBER_OF_FRAMES_P);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(TOTAL - 1);
    localparam logic [ITER_W-1:0] PT_LAST   = ITER_W'(POINTS_PER_LINE_P - 1);

    if (POINTS_PER_LINE_P < 1 || TOTAL < 2 || TOTAL > 65536 || PACE_DIV_P < 1) begin : g_bad_params
        $error("theta_iter_seq: illegal POINTS/FRAMES/PACE parameter combination");
    end

    seq_state_t        state, state_nxt;
    logic              expire;
    logic              issue_nxt;
    logic [ITER_W-1:0] iter_nxt, point_nxt, frame_nxt;
    logic [ITER_W-1:0] up_iter, up_point, up_frame;
    logic              line_nxt, sweep_nxt;
`ifdef THETA_ITER_BIDIR_EN
    logic              down_q, down_nxt;
    logic [ITER_W-1:0] dn_iter, dn_point, dn_frame;
`endif

    theta_pace_cnt #(.PACE_DIV_P(PACE_DIV_P)) u_pace (
        .clk    (clk_i),
        .rst    (rst_i),
        .load   (state == ST_ISSUE),
        .expire (expire)
    );

    // Next-state decode; stop always wins and the final issue returns to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_i && !stop_i) state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                if (stop_i || sweep_done_o)  state_nxt = ST_IDLE;
                else if (PACE_DIV_P > 1)     state_nxt = ST_WAIT;
                else                         state_nxt = ST_ISSUE;
            end
            ST_WAIT: begin
                if (stop_i)      state_nxt = ST_IDLE;
                else if (expire) state_nxt = ST_ISSUE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign issue_nxt = (state_nxt == ST_ISSUE);

    // Incrementing point/frame counters stand in for a divider.
    always_comb begin
        up_iter  = theta_iteration_o + ITER_W'(1);
        up_point = point_idx_o + ITER_W'(1);
        up_frame = frame_idx_o;
        if (point_idx_o == PT_LAST) begin
            up_point = '0;
            up_frame = frame_idx_o + ITER_W'(1);
        end
    end

`ifdef THETA_ITER_BIDIR_EN
    // Decrementing counters for the return pass, wrapping point 0 -> POINTS-1.
    always_comb begin
        dn_iter  = theta_iteration_o - ITER_W'(1);
        dn_point = point_idx_o - ITER_W'(1);
        dn_frame = frame_idx_o;
        if (point_idx_o == '0) begin
            dn_point = PT_LAST;
            dn_frame = frame_idx_o - ITER_W'(1);
        end
    end
`endif

    // Value presented on the next ISSUE: zero when leaving IDLE, else stepped.
    always_comb begin
        iter_nxt  = '0;
        point_nxt = '0;
        frame_nxt = '0;
`ifdef THETA_ITER_BIDIR_EN
        down_nxt  = 1'b0;
        if (state != ST_IDLE) begin
            // The peak is issued once; the step after it already heads down.
            down_nxt = down_q || (theta_iteration_o == ITER_LAST);
            if (down_nxt) begin
                iter_nxt  = dn_iter;
                point_nxt = dn_point;
                frame_nxt = dn_frame;
            end else begin
                iter_nxt  = up_iter;
                point_nxt = up_point;
                frame_nxt = up_frame;
            end
        end
`else
        if (state != ST_IDLE) begin
            iter_nxt  = up_iter;
            point_nxt = up_point;
            frame_nxt = up_frame;
        end
`endif
    end

`ifdef THETA_ITER_BIDIR_EN
    assign line_nxt  = down_nxt ? (point_nxt == '0) : (point_nxt == PT_LAST);
    assign sweep_nxt = down_nxt && (iter_nxt == '0);
`else
    assign line_nxt  = (point_nxt == PT_LAST);
    assign sweep_nxt = (iter_nxt == ITER_LAST);
`endif

    // State and registered outputs; indices only move on an issue.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state                   <= ST_IDLE;
            theta_iteration_valid_o <= 1'b0;
            theta_iteration_o       <= '0;
            point_idx_o             <= '0;
            frame_idx_o             <= '0;
            line_done_o             <= 1'b0;
            sweep_done_o            <= 1'b0;
            busy_o                  <= 1'b0;
`ifdef THETA_ITER_BIDIR_EN
            down_q                  <= 1'b0;
`endif
        end else begin
            state                   <= state_nxt;
            theta_iteration_valid_o <= issue_nxt;
            busy_o                  <= (state_nxt != ST_IDLE);
            line_done_o             <= issue_nxt && line_nxt;
            sweep_done_o            <= issue_nxt && sweep_nxt;
            if (issue_nxt) begin
                theta_iteration_o <= iter_nxt;
                point_idx_o       <= point_nxt;
                frame_idx_o       <= frame_nxt;
`ifdef THETA_ITER_BIDIR_EN
                down_q            <= down_nxt;
`endif
            end
        end
    end

endmodule

// File: tb/tb_theta_iter_seq.sv
// Self-checking bench for theta_iter_seq. Three instances cover PACE=3 with a
// short sweep, PACE=1 with the full 360x5 sweep, and PACE=1 with a short sweep.
// Expected issues are queued per instance when a start is driven and popped
// as valids appear.
module tb_theta_iter_seq;

`ifdef THETA_ITER_BIDIR_EN
    localparam bit BIDIR = 1'b1;
`else
    localparam bit BIDIR = 1'b0;
`endif

    localparam int PTS [3] = '{4, 360, 4};
    localparam int FRM [3] = '{2, 5, 2};
    localparam int PCE [3] = '{3, 1, 1};

    typedef struct {
        int cyc;
        int c0;
        int it;
        int pt;
        int fr;
        bit ln;
        bit sw;
    } exp_t;

    exp_t sb [3][$];

    logic        clk = 1'b0;
    logic        rst;
    logic        start_v [3];
    logic        stop_v  [3];
    logic        val_v   [3];
    logic [15:0] th_v    [3];
    logic [15:0] pt_v    [3];
    logic [15:0] fr_v    [3];
    logic        ln_v    [3];
    logic        sw_v    [3];
    logic        busy_v  [3];

    int cyc;
    int n_checks;
    int n_errors;
    int last_it [3];
    int nval    [3];
    int nsw     [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        theta_iter_seq #(
            .POINTS_PER_LINE_P (PTS[g]),
            .NUMBER_OF_FRAMES_P(FRM[g]),
            .PACE_DIV_P        (PCE[g])
        ) u_dut (
            .clk_i                  (clk),
            .rst_i                  (rst),
            .start_i                (start_v[g]),
            .stop_i                 (stop_v[g]),
            .theta_iteration_valid_o(val_v[g]),
            .theta_iteration_o      (th_v[g]),
            .point_idx_o            (pt_v[g]),
            .frame_idx_o            (fr_v[g]),
            .line_done_o            (ln_v[g]),
            .sweep_done_o           (sw_v[g]),
            .busy_o                 (busy_v[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Queue the full expected issue sequence for a sweep accepted this cycle.
    task automatic push_sweep(input int id);
        exp_t e;
        int   total;
        int   n;
        bit   dn;
        total = PTS[id] * FRM[id];
        n     = BIDIR ? 2 * total - 1 : total;
        for (int k = 0; k < n; k++) begin
            dn    = (k >= total);
            e.it  = dn ? 2 * (total - 1) - k : k;
            e.pt  = e.it % PTS[id];
            e.fr  = e.it / PTS[id];
            e.ln  = dn ? (e.pt == 0) : (e.pt == PTS[id] - 1);
            e.sw  = (k == n - 1);
            e.cyc = cyc + 1 + k * PCE[id];
            e.c0  = cyc + 1;
            sb[id].push_back(e);
        end
    endtask

    task automatic cmp_dut(input int id);
        exp_t  e;
        bit    busy_exp;
        string p;
        p        = $sformatf("d%0d", id);
        busy_exp = (sb[id].size() > 0) && (cyc >= sb[id][0].c0);
        chk({p, "_busy"}, 32'(busy_v[id]), 32'(busy_exp));
        if (val_v[id] === 1'b1) begin
            nval[id]++;
            if (sw_v[id] === 1'b1) nsw[id]++;
            if (sb[id].size() == 0) begin
                chk({p, "_valid"}, 32'(val_v[id]), 32'd0);
            end else begin
                e = sb[id].pop_front();
                chk({p, "_cycle"}, cyc, e.cyc);
                chk({p, "_iter"},  32'(th_v[id]), e.it);
                chk({p, "_point"}, 32'(pt_v[id]), e.pt);
                chk({p, "_frame"}, 32'(fr_v[id]), e.fr);
                chk({p, "_line"},  32'(ln_v[id]), 32'(e.ln));
                chk({p, "_sweep"}, 32'(sw_v[id]), 32'(e.sw));
                last_it[id] = e.it;
            end
        end else begin
            chk({p, "_hold"},    32'(th_v[id]), last_it[id]);
            chk({p, "_strobes"}, 32'({ln_v[id], sw_v[id]}), 32'd0);
            if (sb[id].size() > 0 && sb[id][0].cyc <= cyc) begin
                chk({p, "_valid"}, 32'(val_v[id]), 32'd1);
                void'(sb[id].pop_front());
            end
        end
    endtask

    // Check the current cycle, apply stop pruning, then advance one clock.
    task automatic step();
        for (int i = 0; i < 3; i++) cmp_dut(i);
        for (int i = 0; i < 3; i++) begin
            if (stop_v[i]) begin
                while (sb[i].size() > 0 && sb[i][$].cyc > cyc) void'(sb[i].pop_back());
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                sb[i].delete();
                last_it[i] = 0;
            end
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic start_sweep(input int id, input bit with_stop);
        if (!with_stop && sb[id].size() == 0) push_sweep(id);
        start_v[id] = 1'b1;
        stop_v[id]  = with_stop;
        step();
        start_v[id] = 1'b0;
        stop_v[id]  = 1'b0;
    endtask

    task automatic drain(input int id, input int budget);
        int k;
        k = 0;
        while (sb[id].size() > 0 && k < budget) begin
            step();
            k++;
        end
        chk($sformatf("d%0d_drain", id), sb[id].size(), 0);
        run(3);
    endtask

    task automatic chk_zero(input int id);
        string p;
        p = $sformatf("d%0d_rst", id);
        chk({p, "_valid"}, 32'(val_v[id]), 0);
        chk({p, "_iter"},  32'(th_v[id]), 0);
        chk({p, "_point"}, 32'(pt_v[id]), 0);
        chk({p, "_frame"}, 32'(fr_v[id]), 0);
        chk({p, "_line"},  32'(ln_v[id]), 0);
        chk({p, "_sweep"}, 32'(sw_v[id]), 0);
        chk({p, "_busy"},  32'(busy_v[id]), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        rst      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            stop_v[i]  = 1'b0;
            last_it[i] = 0;
            nval[i]    = 0;
            nsw[i]     = 0;
        end

        // Reset held for three cycles
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        for (int i = 0; i < 3; i++) chk_zero(i);
        rst = 1'b0;
        run(2);

        // Basic paced sweep
        start_sweep(0, 1'b0);
        drain(0, 100);

        // Abort during WAIT, then restart from 0
        start_sweep(0, 1'b0);
        run(7);
        stop_v[0] = 1'b1;
        step();
        stop_v[0] = 1'b0;
        run(5);
        start_sweep(0, 1'b0);
        drain(0, 100);

        // Start ignored mid-sweep
        start_sweep(0, 1'b0);
        run(5);
        start_sweep(0, 1'b0);
        drain(0, 100);

        // Start together with stop in IDLE
        start_sweep(0, 1'b1);
        run(6);

        // Reset mid-sweep, then a fresh sweep from 0
        start_sweep(0, 1'b0);
        run(9);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_zero(0);
        run(3);
        start_sweep(0, 1'b0);
        drain(0, 100);

        // Full-length sweep at one issue per cycle
        start_sweep(1, 1'b0);
        drain(1, 4000);
        chk("d1_n_valid", nval[1], BIDIR ? 3599 : 1800);
        chk("d1_n_sweep", nsw[1], 1);

        // Short sweep at one issue per cycle
        start_sweep(2, 1'b0);
        drain(2, 100);
        chk("d2_n_valid", nval[2], BIDIR ? 15 : 8);
        chk("d2_n_sweep", nsw[2], 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
